// File: rtl/puf_key_reader.sv
// -----------------------------------------------------------------------------
// puf_key_reader
//
// Sequences the 8-bit ring-oscillator PUF through its four challenges, lets it
// settle, samples its response SAMPLES times per challenge and majority-votes
// each bit into a stable byte. The four bytes form a 32-bit device key handed
// to the root-of-trust logic through a start/done handshake.
//
// Optional feature macro: PUF_STABILITY_CHECK_EN
//   defined   -> unstable_mask flags every key bit whose samples disagreed
//   undefined -> unstable_mask is tied to zero, no comparison logic is built
//
// Ports:
//   clk            in   single rising-edge clock
//   rst_n          in   asynchronous active-low reset
//   start          in   request a key read (accepted only while idle)
//   abort          in   cancel an in-progress read, clearing the key
//   puf_response   in   8-bit response of the PUF generator
//   puf_enable     out  generator enable
//   puf_control    out  2-bit challenge index driven to the generator
//   busy           out  read in progress
//   done           out  one-cycle pulse when the key is complete
//   key_valid      out  key holds a complete result
//   key            out  assembled key, byte i = voted response of challenge i
//   unstable_mask  out  key bits whose samples were not unanimous
// -----------------------------------------------------------------------------
module puf_key_reader #(
    parameter int unsigned SETTLE_CYCLES = 16,
    parameter int unsigned SAMPLES       = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic [7:0]  puf_response,
    output logic        puf_enable,
    output logic [1:0]  puf_control,
    output logic        busy,
    output logic        done,
    output logic        key_valid,
    output logic [31:0] key,
    output logic [31:0] unstable_mask
);

    localparam int unsigned CNT_W   = $clog2(SAMPLES + 1);
    localparam int unsigned TMR_MAX = (SETTLE_CYCLES > SAMPLES) ? SETTLE_CYCLES : SAMPLES;
    localparam int unsigned TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

    // The timer counts down to zero, so each phase loads its length minus one.
    localparam logic [TMR_W-1:0] SETTLE_LOAD = TMR_W'(SETTLE_CYCLES - 1);
    localparam logic [TMR_W-1:0] SAMPLE_LOAD = TMR_W'(SAMPLES - 1);
    localparam logic [CNT_W-1:0] HALF        = CNT_W'(SAMPLES / 2);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_COMMIT,
        ST_DONE
    } state_e;

    state_e             state_q, state_d;
    logic [1:0]         index_q, index_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [CNT_W-1:0]   ones_q [8];
    logic [CNT_W-1:0]   ones_d [8];
    logic [31:0]        key_q, key_d;
    logic               key_valid_q, key_valid_d;
    logic               puf_enable_q, puf_enable_d;
    logic [1:0]         puf_control_q, puf_control_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [7:0]         vote;
`ifdef PUF_STABILITY_CHECK_EN
    logic [31:0]        mask_q, mask_d;
    logic [7:0]         unstable_bits;
`endif

    // NOTE: every variable driven here gets a default first, otherwise paths
    // that skip an assignment would infer latches.
    always_comb begin
        state_d     = state_q;
        index_d     = index_q;
        timer_d     = timer_q;
        ones_d      = ones_q;
        key_d       = key_q;
        key_valid_d = key_valid_q;
        vote        = '0;
`ifdef PUF_STABILITY_CHECK_EN
        mask_d        = mask_q;
        unstable_bits = '0;
`endif

        for (int b = 0; b < 8; b++) begin
            vote[b] = (ones_q[b] > HALF);
`ifdef PUF_STABILITY_CHECK_EN
            unstable_bits[b] = (ones_q[b] != '0) && (ones_q[b] != CNT_W'(SAMPLES));
`endif
        end

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d     = ST_SETTLE;
                    index_d     = 2'd0;
                    timer_d     = SETTLE_LOAD;
                    key_d       = '0;
                    key_valid_d = 1'b0;
                    ones_d      = '{default: '0};
`ifdef PUF_STABILITY_CHECK_EN
                    mask_d      = '0;
`endif
                end
            end
            ST_SETTLE: begin
                if (timer_q == '0) begin
                    state_d = ST_SAMPLE;
                    timer_d = SAMPLE_LOAD;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            ST_SAMPLE: begin
                for (int b = 0; b < 8; b++) begin
                    ones_d[b] = ones_q[b] + CNT_W'(puf_response[b]);
                end
                if (timer_q == '0) begin
                    state_d = ST_COMMIT;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            ST_COMMIT: begin
                key_d[{index_q, 3'b000} +: 8] = vote;
`ifdef PUF_STABILITY_CHECK_EN
                mask_d[{index_q, 3'b000} +: 8] = unstable_bits;
`endif
                ones_d = '{default: '0};
                if (index_q == 2'd3) begin
                    state_d     = ST_DONE;
                    key_valid_d = 1'b1;
                end else begin
                    state_d = ST_SETTLE;
                    index_d = index_q + 2'd1;
                    timer_d = SETTLE_LOAD;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Abort overrides whatever the active state decided.
        if (abort && (state_q != ST_IDLE)) begin
            state_d     = ST_IDLE;
            key_d       = '0;
            key_valid_d = 1'b0;
            ones_d      = '{default: '0};
`ifdef PUF_STABILITY_CHECK_EN
            mask_d      = '0;
`endif
        end

        // Outputs are registered, so they are decoded from the next state.
        // The challenge index only moves on the COMMIT->SETTLE edge, so
        // puf_control is stable throughout settling and sampling.
        puf_enable_d  = (state_d == ST_SETTLE) || (state_d == ST_SAMPLE) ||
                        (state_d == ST_COMMIT);
        puf_control_d = (state_d == ST_IDLE) ? 2'd0 : index_d;
        busy_d        = (state_d != ST_IDLE);
        done_d        = (state_d == ST_DONE);
    end

    // NOTE: sequential state uses non-blocking assignments only; the blocking
    // assignments above are confined to combinational next-state logic.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            index_q       <= '0;
            timer_q       <= '0;
            key_q         <= '0;
            key_valid_q   <= 1'b0;
            puf_enable_q  <= 1'b0;
            puf_control_q <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            // NOTE: the ones counters are a small register array, not a RAM,
            // so they are reset like any other state.
            for (int b = 0; b < 8; b++) begin
                ones_q[b] <= '0;
            end
        end else begin
            state_q       <= state_d;
            index_q       <= index_d;
            timer_q       <= timer_d;
            key_q         <= key_d;
            key_valid_q   <= key_valid_d;
            puf_enable_q  <= puf_enable_d;
            puf_control_q <= puf_control_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            ones_q        <= ones_d;
        end
    end

`ifdef PUF_STABILITY_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_q <= '0;
        end else begin
            mask_q <= mask_d;
        end
    end

    assign unstable_mask = mask_q;
`else
    assign unstable_mask = '0;
`endif

    assign puf_enable  = puf_enable_q;
    assign puf_control = puf_control_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign key_valid   = key_valid_q;
    assign key         = key_q;

endmodule

// File: tb/tb_puf_key_reader.sv
// -----------------------------------------------------------------------------
// tb_puf_key_reader
//
// Two instances: one with default timing (16 settle, 5 samples) and one with
// the minimum timing (1 settle, 1 sample). A per-read table of response bytes
// is played to the selected instance only during the sampling window of each
// challenge; outside it the response is random noise that must be ignored.
// The expected key and unstable mask are derived from the table by counting
// ones per bit and applying the majority rule.
// -----------------------------------------------------------------------------
module tb_puf_key_reader;

    logic clk;
    logic rst_n;

    logic        s0_start, s0_abort;
    logic [7:0]  s0_resp;
    logic        d0_en, d0_busy, d0_done, d0_kv;
    logic [1:0]  d0_ctrl;
    logic [31:0] d0_key, d0_mask;

    logic        s1_start, s1_abort;
    logic [7:0]  s1_resp;
    logic        d1_en, d1_busy, d1_done, d1_kv;
    logic [1:0]  d1_ctrl;
    logic [31:0] d1_key, d1_mask;

    bit          sel;
    logic        obs_en, obs_busy, obs_done, obs_kv;
    logic [1:0]  obs_ctrl;
    logic [31:0] obs_key, obs_mask;

    int          n_tests;
    int          n_fail;
    logic [7:0]  smp [4][15];
    logic [31:0] last_key;

    puf_key_reader u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (s0_start),
        .abort         (s0_abort),
        .puf_response  (s0_resp),
        .puf_enable    (d0_en),
        .puf_control   (d0_ctrl),
        .busy          (d0_busy),
        .done          (d0_done),
        .key_valid     (d0_kv),
        .key           (d0_key),
        .unstable_mask (d0_mask)
    );

    puf_key_reader #(
        .SETTLE_CYCLES (1),
        .SAMPLES       (1)
    ) u_dut_fast (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (s1_start),
        .abort         (s1_abort),
        .puf_response  (s1_resp),
        .puf_enable    (d1_en),
        .puf_control   (d1_ctrl),
        .busy          (d1_busy),
        .done          (d1_done),
        .key_valid     (d1_kv),
        .key           (d1_key),
        .unstable_mask (d1_mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        if (sel) begin
            obs_en = d1_en; obs_busy = d1_busy; obs_done = d1_done; obs_kv = d1_kv;
            obs_ctrl = d1_ctrl; obs_key = d1_key; obs_mask = d1_mask;
        end else begin
            obs_en = d0_en; obs_busy = d0_busy; obs_done = d0_done; obs_kv = d0_kv;
            obs_ctrl = d0_ctrl; obs_key = d0_key; obs_mask = d0_mask;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pack(input logic b, input logic e, input logic [1:0] c,
                                         input logic d, input logic v);
        return 32'({b, e, c, d, v});
    endfunction

    task automatic drive(input logic st, input logic ab, input logic [7:0] rsp);
        if (sel) begin
            s1_start = st; s1_abort = ab; s1_resp = rsp;
        end else begin
            s0_start = st; s0_abort = ab; s0_resp = rsp;
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_status"}, pack(obs_busy, obs_en, obs_ctrl, obs_done, obs_kv), 32'd0);
        check({tag, "_key"}, obs_key, 32'd0);
        check({tag, "_mask"}, obs_mask, 32'd0);
    endtask

    task automatic fill_const();
        for (int ch = 0; ch < 4; ch++)
            for (int k = 0; k < 15; k++)
                smp[ch][k] = 8'hA5 + 8'(ch);
    endtask

    // Each challenge has a preferred byte; every sample flips a few bits.
    task automatic fill_random();
        logic [7:0] base;
        for (int ch = 0; ch < 4; ch++) begin
            base = 8'($urandom);
            for (int k = 0; k < 15; k++)
                smp[ch][k] = base ^ 8'($urandom & $urandom & $urandom);
        end
    endtask

    // One key read on the selected instance. Cycle n=1 is the first cycle
    // after the edge that captured start. abort_at/restart_at/rst_at name the
    // cycle in which that event is applied (0 = never).
    task automatic do_read(input int abort_at, input int restart_at, input int rst_at,
                           input bit with_abort);
        int          st, ns, per, total, ch, pos, cnt, done_cnt;
        logic [31:0] ek, em;
        logic [7:0]  rsp;
        st    = sel ? 1 : 16;
        ns    = sel ? 1 : 5;
        per   = st + ns + 1;
        total = 1 + 4 * per;
        ek    = '0;
        em    = '0;
        for (int c = 0; c < 4; c++) begin
            for (int b = 0; b < 8; b++) begin
                cnt = 0;
                for (int k = 0; k < ns; k++) cnt += int'(smp[c][k][b]);
                ek[8*c+b] = (2 * cnt > ns);
                em[8*c+b] = (cnt != 0) && (cnt != ns);
            end
        end
`ifndef PUF_STABILITY_CHECK_EN
        em = '0;
`endif

        @(negedge clk);
        drive(1'b1, with_abort, 8'($urandom));
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 8'($urandom));
        done_cnt = 0;

        for (int n = 1; n <= total + 3; n++) begin
            ch  = (n - 1) / per;
            pos = (n - 1) % per;
            if (obs_done === 1'b1) done_cnt++;

            if (n < total) begin
                check("during_read", pack(obs_busy, obs_en, obs_ctrl, obs_done, obs_kv),
                      pack(1'b1, 1'b1, 2'(ch), 1'b0, 1'b0));
            end else if (n == total) begin
                check("done_cycle", pack(obs_busy, obs_en, 2'b00, obs_done, obs_kv),
                      pack(1'b1, 1'b0, 2'b00, 1'b1, 1'b1));
                check("key", obs_key, ek);
                check("unstable_mask", obs_mask, em);
                last_key = ek;
            end else begin
                check("after_done", pack(obs_busy, obs_en, obs_ctrl, obs_done, obs_kv),
                      pack(1'b0, 1'b0, 2'b00, 1'b0, 1'b1));
                check("key_hold", obs_key, ek);
            end

            if ((n < total) && (pos >= st) && (pos < st + ns)) rsp = smp[ch][pos-st];
            else rsp = 8'($urandom);
            drive(n == restart_at, n == abort_at, rsp);

            if (n == abort_at) begin
                @(posedge clk);
                #1;
                drive(1'b0, 1'b0, 8'd0);
                check("abort_status", pack(obs_busy, obs_en, obs_ctrl, obs_done, obs_kv), 32'd0);
                check("abort_key", obs_key, 32'd0);
                check("abort_mask", obs_mask, 32'd0);
                @(posedge clk);
                #1;
                check("abort_no_done", pack(obs_busy, obs_en, obs_ctrl, obs_done, obs_kv), 32'd0);
                last_key = '0;
                return;
            end
            if (n == rst_at) begin
                rst_n = 1'b0;
                #1;
                check_reset("reset_mid_read");
                drive(1'b0, 1'b0, 8'd0);
                @(negedge clk);
                rst_n = 1'b1;
                last_key = '0;
                return;
            end
            @(posedge clk);
            #1;
        end
        check("single_done", 32'(done_cnt), 32'd1);
    endtask

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        sel      = 1'b0;
        last_key = '0;
        rst_n    = 1'b0;
        s0_start = 1'b0; s0_abort = 1'b0; s0_resp = '0;
        s1_start = 1'b0; s1_abort = 1'b0; s1_resp = '0;
        fill_const();

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_reset("reset_dut");
        sel = 1'b1;
        #1;
        check_reset("reset_dut_fast");
        sel = 1'b0;
        #1;

        // Constant responses 8'hA5+i.
        fill_const();
        do_read(0, 0, 0, 1'b0);
        check("const_key", obs_key, 32'hA8A7A6A5);
        check("const_mask", obs_mask, 32'd0);

        // Bit 0 of challenge 2 flipped on 2 of 5 samples: majority still 1.
        smp[2][1] ^= 8'h01;
        smp[2][3] ^= 8'h01;
        do_read(0, 0, 0, 1'b0);
        check("flip_key_bit16", 32'(obs_key[16]), 32'd1);
`ifdef PUF_STABILITY_CHECK_EN
        check("flip_mask", obs_mask, 32'h0001_0000);
`else
        check("flip_mask", obs_mask, 32'd0);
`endif

        // Abort while idle has no effect.
        @(negedge clk);
        drive(1'b0, 1'b1, 8'd0);
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 8'd0);
        check("idle_abort_status", pack(obs_busy, obs_en, obs_ctrl, obs_done, obs_kv),
              pack(1'b0, 1'b0, 2'b00, 1'b0, 1'b1));
        check("idle_abort_key", obs_key, last_key);

        // Random responses; a second start at cycle 30 must be ignored.
        fill_random();
        do_read(0, 30, 0, 1'b0);

        // Abort during SAMPLE of challenge 1.
        fill_random();
        do_read(40, 0, 0, 1'b0);

        // Reset during SETTLE of challenge 3, then a clean read.
        fill_random();
        do_read(0, 0, 72, 1'b0);
        fill_random();
        do_read(0, 0, 0, 1'b0);

        // Abort together with start in IDLE: start wins.
        fill_random();
        do_read(0, 0, 0, 1'b1);

        fill_random();
        do_read(0, 0, 0, 1'b0);

        // Minimum timing instance: 13-cycle reads, single sample per byte.
        sel = 1'b1;
        #1;
        fill_const();
        do_read(0, 0, 0, 1'b0);
        check("fast_const_key", obs_key, 32'hA8A7A6A5);
        for (int r = 0; r < 4; r++) begin
            fill_random();
            do_read(0, 0, 0, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
